// File: rtl/edge_pkg.sv
// Shared types for the multi-channel edge detector: per-channel edge mode
// and debounce FSM state.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } deb_state_t;

endpackage

// File: rtl/edge_channel.sv
// One detector channel: synchroniser, debounce FSM, edge qualification,
// sticky pending flag and saturating event counter.
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC  = 2,
    parameter int DEB   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  edge_mode_t       mode,
    input  logic             clr,
    output logic             level,
    output logic             tick,
    output logic             pending,
    output logic [CNT_W-1:0] count
);

    localparam int RUN_W = $clog2(DEB + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB - 1);

    logic [SYNC-1:0]  sync_q;
    logic             s;
    deb_state_t       state, state_nx;
    logic [RUN_W-1:0] run, run_nx;
    logic             flip;
    logic             event_q;

    assign s = sync_q[SYNC-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC-2:0], sig};
    end

    always_comb begin
        state_nx = state;
        run_nx   = run;
        flip     = 1'b0;
        case (state)
            STABLE: begin
                if (s != level) begin
                    if (DEB == 1) begin
                        flip = 1'b1;
                    end else begin
                        state_nx = CHANGING;
                        run_nx   = RUN_W'(1);
                    end
                end
            end
            CHANGING: begin
                if (s == level) begin
                    // Input fell back before the run completed: glitch rejected.
                    state_nx = STABLE;
                    run_nx   = '0;
                end else if (run == RUN_LAST) begin
                    flip     = 1'b1;
                    state_nx = STABLE;
                    run_nx   = '0;
                end else begin
                    run_nx = run + RUN_W'(1);
                end
            end
            default: begin
                state_nx = STABLE;
                run_nx   = '0;
            end
        endcase
    end

    // Flip direction equals the new level, which is s at the flip edge.
    assign event_q = flip && ((s && mode[0]) || (!s && mode[1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STABLE;
            run     <= '0;
            level   <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            count   <= '0;
        end else begin
            state <= state_nx;
            run   <= run_nx;
            tick  <= event_q;
            if (flip) level <= s;
            if (event_q)  pending <= 1'b1;
            else if (clr) pending <= 1'b0;
            if (clr)                        count <= event_q ? CNT_W'(1) : '0;
            else if (event_q && count != '1) count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector top: slices the flat mode/count buses and
// instantiates one independent edge_channel per input.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int CH    = 4,
    parameter int SYNC  = 2,
    parameter int DEB   = 1,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       sig,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       level,
    output logic [CH-1:0]       tick,
    output logic [CH-1:0]       pending,
    output logic [CH*CNT_W-1:0] count
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_channel #(
            .SYNC (SYNC),
            .DEB  (DEB),
            .CNT_W(CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .sig    (sig[i]),
            .mode   (edge_mode_t'(mode[2*i+1:2*i])),
            .clr    (clr[i]),
            .level  (level[i]),
            .tick   (tick[i]),
            .pending(pending[i]),
            .count  (count[CNT_W*(i+1)-1:CNT_W*i])
        );
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with a window-based reference model
// compared every cycle, plus literal checkpoints along the test plan.
module tb_multi_edge_detector;

    localparam int CH = 4, SYNC = 2, DEB = 3, CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;
    localparam int HMAX = 4096;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [CH-1:0]       sig = '0;
    logic [2*CH-1:0]     mode = '0;
    logic [CH-1:0]       clr = '0;
    logic [CH-1:0]       level, tick, pending;
    logic [CH*CNT_W-1:0] count;

    int total = 0;
    int bad = 0;

    multi_edge_detector #(.CH(CH), .SYNC(SYNC), .DEB(DEB), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sig(sig), .mode(mode), .clr(clr),
        .level(level), .tick(tick), .pending(pending), .count(count)
    );

    always #5 clk = ~clk;

    // Model: the filtered level flips when the last DEB synchronised samples all
    // differ from it; the synchronised sample is the raw input SYNC edges ago.
    bit hist [CH][HMAX];
    int n_edge;
    bit m_lvl [CH];
    bit m_tick [CH];
    bit m_pend [CH];
    int m_cnt [CH];

    function automatic bit s_at(int c, int m);
        int idx;
        idx = m - SYNC;
        if (idx < 0 || idx >= HMAX) return 1'b0;
        return hist[c][idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edge = 0;
            for (int c = 0; c < CH; c++) begin
                m_lvl[c] = 0; m_tick[c] = 0; m_pend[c] = 0; m_cnt[c] = 0;
                for (int k = 0; k < HMAX; k++) hist[c][k] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                bit flip, ev, nl;
                int md;
                if (n_edge < HMAX) hist[c][n_edge] = sig[c];
                flip = 1;
                for (int j = 0; j < DEB; j++)
                    if (s_at(c, n_edge - j) == m_lvl[c]) flip = 0;
                nl = !m_lvl[c];
                md = int'(mode[2*c +: 2]);
                ev = flip && ((nl && (md == 1 || md == 3)) || (!nl && (md == 2 || md == 3)));
                if (flip) m_lvl[c] = nl;
                m_tick[c] = ev;
                if (ev) m_pend[c] = 1;
                else if (clr[c]) m_pend[c] = 0;
                if (clr[c]) m_cnt[c] = ev ? 1 : 0;
                else if (ev && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
            end
            n_edge++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int cnt_of(int c);
        return int'(count[CNT_W*c +: CNT_W]);
    endfunction

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("model_level%0d", c), int'(level[c]), int'(m_lvl[c]));
            chk($sformatf("model_tick%0d", c), int'(tick[c]), int'(m_tick[c]));
            chk($sformatf("model_pend%0d", c), int'(pending[c]), int'(m_pend[c]));
            chk($sformatf("model_cnt%0d", c), cnt_of(c), m_cnt[c]);
        end
    end

    task automatic wait_neg(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse(input int c, input int hi, input int lo);
        sig[c] = 1'b1; wait_neg(hi);
        sig[c] = 1'b0; wait_neg(lo);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_level", int'(level), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_count", int'(count), 0);
        mode = {2'b01, 2'b10, 2'b11, 2'b01};  // ch3 RISE, ch2 FALL, ch1 BOTH, ch0 RISE
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(3);

        // ch0 rise: tick only after posedge k+4
        sig[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("ch0_tick_early", int'(tick[0]), 0);
        @(posedge clk);
        #1 chk("ch0_tick_k4", int'(tick[0]), 1);
        chk("ch0_level_k4", int'(level[0]), 1);
        @(posedge clk);
        #1 chk("ch0_tick_k5", int'(tick[0]), 0);
        chk("ch0_pend", int'(pending[0]), 1);
        chk("ch0_cnt", cnt_of(0), 1);
        wait_neg(8);

        // ch1 BOTH: 2-cycle glitch rejected, 6-cycle pulse gives two edges
        pulse(1, 2, 8);
        chk("ch1_glitch_level", int'(level[1]), 0);
        chk("ch1_glitch_cnt", cnt_of(1), 0);
        pulse(1, 6, 10);
        chk("ch1_pulse_cnt", cnt_of(1), 2);

        // ch2 FALL then OFF
        for (int p = 0; p < 3; p++) pulse(2, 5, 5);
        wait_neg(3);
        chk("ch2_fall_cnt", cnt_of(2), 3);
        mode[5:4] = 2'b00;
        for (int p = 0; p < 2; p++) pulse(2, 5, 5);
        wait_neg(3);
        chk("ch2_off_cnt", cnt_of(2), 3);

        // ch3 saturation and clr interplay
        for (int p = 0; p < 20; p++) pulse(3, 4, 4);
        wait_neg(4);
        chk("ch3_sat_cnt", cnt_of(3), CMAX);
        sig[3] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr[3] = 1'b1;
        @(posedge clk);
        #1 chk("ch3_clr_tick", int'(tick[3]), 1);
        chk("ch3_clr_ev_cnt", cnt_of(3), 1);
        chk("ch3_clr_ev_pend", int'(pending[3]), 1);
        @(negedge clk);
        clr[3] = 1'b0;
        wait_neg(3);
        clr[3] = 1'b1;
        wait_neg(1);
        clr[3] = 1'b0;
        chk("ch3_clr_cnt", cnt_of(3), 0);
        chk("ch3_clr_pend", int'(pending[3]), 0);
        sig[3] = 1'b0;
        wait_neg(8);

        // Reset in the middle of ch0 debounce
        sig[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_pend", int'(pending), 0);
        chk("mid_rst_count", int'(count), 0);
        @(negedge clk);
        sig[0] = 1'b1;
        wait_neg(2);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("rel_tick_early", int'(tick[0]), 0);
        @(posedge clk);
        #1 chk("rel_tick", int'(tick[0]), 1);
        @(posedge clk);
        #1 chk("rel_tick_once", int'(tick[0]), 0);
        chk("rel_cnt", cnt_of(0), 1);
        @(negedge clk);

        // All channels toggled together with different modes
        sig = '0;
        mode = {2'b00, 2'b10, 2'b11, 2'b01};  // ch3 OFF, ch2 FALL, ch1 BOTH, ch0 RISE
        wait_neg(8);
        clr = '1;
        wait_neg(1);
        clr = '0;
        sig = '1; wait_neg(6);
        sig = '0; wait_neg(6);
        sig = '1; wait_neg(8);
        chk("all_cnt0", cnt_of(0), 2);
        chk("all_cnt1", cnt_of(1), 3);
        chk("all_cnt2", cnt_of(2), 1);
        chk("all_cnt3", cnt_of(3), 0);
        chk("all_level", int'(level), 4'hF);

        wait_neg(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
